// File: rtl/fp_pkg.sv
// Shared FP definitions for the FP datapath: IEEE-754 single precision field
// widths, bias, canonical zero and the int-to-float converter state type.
package fp_pkg;

    localparam int FP_BIAS  = 127;
    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;

    localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;

    // Exponent of a magnitude whose MSB sits in bit 31: bias + 31.
    localparam logic [FP_EXP_W-1:0] I2F_EXP_INIT = 8'(FP_BIAS + 31);

    typedef struct packed {
        logic                s;
        logic [FP_EXP_W-1:0] e;
        logic [FP_MAN_W-1:0] m;
    } fp32_t;

    typedef enum logic {
        IDLE = 1'b0,
        NORM = 1'b1
    } i2f_state_t;

endpackage

// File: rtl/int_to_fp_seq.sv
// Serial 32-bit integer to IEEE-754 single-precision converter.
// The magnitude is shifted left one bit per clock until its MSB is set, the
// exponent counting down from bias+31; the low 8 bits are then truncated
// (round toward zero). Zero input yields +0 after a single cycle.
module int_to_fp_seq
    import fp_pkg::*;
#(
    parameter bit UNSIGNED_MODE = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] int_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] fp_out
);

    i2f_state_t    r_state;
    logic          r_sign;
    logic [31:0]   r_mag;
    logic [7:0]    r_exp;
    logic          r_busy;
    logic          r_done;
    fp32_t         r_fp;

    i2f_state_t    w_state;
    logic          w_sign;
    logic [31:0]   w_mag;
    logic [7:0]    w_exp;
    logic          w_busy;
    logic          w_done;
    fp32_t         w_fp;

    // State register; async reset discards any in-flight conversion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_sign  <= 1'b0;
            r_mag   <= 32'h0000_0000;
            r_exp   <= 8'h00;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_fp    <= FP_POS_ZERO;
        end else begin
            r_state <= w_state;
            r_sign  <= w_sign;
            r_mag   <= w_mag;
            r_exp   <= w_exp;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_fp    <= w_fp;
        end
    end

    // Next-state logic: capture in IDLE, one normalisation step per clock in NORM.
    always_comb begin
        w_state = r_state;
        w_sign  = r_sign;
        w_mag   = r_mag;
        w_exp   = r_exp;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_fp    = r_fp;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_sign  = (UNSIGNED_MODE != 1'b0) ? 1'b0 : int_in[31];
                    // 0x8000_0000 negates to itself, which is the correct magnitude.
                    w_mag   = w_sign ? (~int_in + 32'd1) : int_in;
                    w_exp   = I2F_EXP_INIT;
                    w_busy  = 1'b1;
                    w_state = NORM;
                end else begin
                    w_state = IDLE;
                end
            end
            NORM: begin
                if (r_mag == 32'h0000_0000) begin
                    w_fp    = FP_POS_ZERO;
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                    w_state = IDLE;
                end else if (r_mag[31]) begin
                    w_fp    = {r_sign, r_exp, r_mag[30:8]};
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                    w_state = IDLE;
                end else begin
                    w_mag   = {r_mag[30:0], 1'b0};
                    w_exp   = r_exp - 8'd1;
                end
            end
            default: begin
                w_state = IDLE;
                w_busy  = 1'b0;
            end
        endcase
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign fp_out = r_fp;

endmodule

// File: tb/tb_int_to_fp_seq.sv
// Directed scoreboard bench for int_to_fp_seq (signed and unsigned instances).
module tb_int_to_fp_seq;

    logic        clk;
    logic        rst;
    logic        start, start_u;
    logic [31:0] int_in, int_in_u;
    logic        busy, done, busy_u, done_u;
    logic [31:0] fp_out, fp_out_u;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] fp;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];

    int_to_fp_seq #(.UNSIGNED_MODE(1'b0)) dut (
        .clk(clk), .rst(rst), .start(start), .int_in(int_in),
        .busy(busy), .done(done), .fp_out(fp_out)
    );

    int_to_fp_seq #(.UNSIGNED_MODE(1'b1)) dut_u (
        .clk(clk), .rst(rst), .start(start_u), .int_in(int_in_u),
        .busy(busy_u), .done(done_u), .fp_out(fp_out_u)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to measure latency.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done pulse on the signed instance is checked against the scoreboard.
    always @(negedge clk) begin
        if (!rst && done) begin
            n_checks++;
            assert (sb.size() != 0) else begin
                n_errors++;
                $error("FAIL spurious_done observed=done expected=no_done");
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                n_checks++;
                assert (fp_out === e.fp) else begin
                    n_errors++;
                    $error("FAIL fp_out observed=%h expected=%h", fp_out, e.fp);
                end
                n_checks++;
                assert ((cyc - e.acc) === e.lat) else begin
                    n_errors++;
                    $error("FAIL latency observed=%0d expected=%0d (fp %h)", cyc - e.acc, e.lat, e.fp);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive start at the current negedge and record the expectation.
    task automatic drive_now(input logic [31:0] v, input logic [31:0] efp, input int lat);
        exp_t e;
        start  = 1'b1;
        int_in = v;
        e.fp = efp;
        e.acc = cyc + 1;
        e.lat = lat;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_start(input logic [31:0] v, input logic [31:0] efp, input int lat);
        @(negedge clk);
        drive_now(v, efp, lat);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        n_checks++;
        assert (sb.size() == 0) else begin
            n_errors++;
            $error("FAIL drain_timeout observed=%0d pending expected=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run_u(input logic [31:0] v, input logic [31:0] efp, input int lat);
        int acc;
        int n = 0;
        @(negedge clk);
        start_u  = 1'b1;
        int_in_u = v;
        acc = cyc + 1;
        @(negedge clk);
        start_u = 1'b0;
        while (!done_u && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("u_done_seen", {31'd0, done_u}, 32'd1);
        chk("u_fp_out", fp_out_u, efp);
        chk("u_latency", 32'(cyc - acc), 32'(lat));
    endtask

    initial begin
        int n;
        rst = 1'b1;
        start = 1'b0;
        int_in = 32'h0;
        start_u = 1'b0;
        int_in_u = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_fp_out", fp_out, 32'h0000_0000);
        chk("rst_fp_out_u", fp_out_u, 32'h0000_0000);
        rst = 1'b0;

        // Basic conversions.
        do_start(32'h0000_0001, 32'h3F80_0000, 32);
        wait_drain();
        do_start(32'hFFFF_FFFF, 32'hBF80_0000, 32);
        wait_drain();
        do_start(32'h0000_0000, 32'h0000_0000, 1);
        wait_drain();
        do_start(32'h8000_0000, 32'hCF00_0000, 1);
        wait_drain();
        do_start(32'h01FF_FFFF, 32'h4BFF_FFFF, 8);
        wait_drain();
        do_start(32'hFFFF_FF00, 32'hC380_0000, 24);
        wait_drain();

        // Output held after done.
        repeat (3) @(negedge clk);
        chk("hold_fp_out", fp_out, 32'hC380_0000);
        chk("hold_done", {31'd0, done}, 32'd0);

        // Start while busy is ignored.
        do_start(32'h0000_0001, 32'h3F80_0000, 32);
        repeat (2) @(negedge clk);
        chk("busy_high", {31'd0, busy}, 32'd1);
        start = 1'b1;
        int_in = 32'h0000_0005;
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        // Start in the done cycle is accepted (back-to-back).
        do_start(32'h0000_0001, 32'h3F80_0000, 32);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_done_seen", {31'd0, done}, 32'd1);
        drive_now(32'h0000_0005, 32'h40A0_0000, 30);
        wait_drain();

        // Async reset mid-conversion.
        do_start(32'h0000_0001, 32'h3F80_0000, 32);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_fp_out", fp_out, 32'h0000_0000);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("arst_no_done_busy", {31'd0, busy}, 32'd0);
        do_start(32'h01FF_FFFF, 32'h4BFF_FFFF, 8);
        wait_drain();

        // Unsigned instance.
        run_u(32'hFFFF_FFFF, 32'h4F7F_FFFF, 1);
        run_u(32'h8000_0000, 32'h4F00_0000, 1);
        run_u(32'h0000_0001, 32'h3F80_0000, 32);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
